igmv_block_sched: RTL and testbench

//  Sequences the 10-lane igmv matrix-vector engine over a tall matrix stored as N row-blocks.
//  Per block: select the block in the memory banks, pulse igmv ST and wait for the RD rising edge.

---
 rtl/igmv_block_sched.sv | 180 ++++++++++++++++++
 tb/tb_igmv_block_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/igmv_block_sched.sv
// rtl/igmv_block_sched.sv - sequences the igmv engine over N row-blocks and serialises lane results
module igmv_block_sched #(
    parameter int LANES          = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int BLK_WIDTH      = 8,
    parameter int RES_ADDR_WIDTH = 12,
    parameter int TIMEOUT        = 255
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic [BLK_WIDTH-1:0]          NUM_BLOCKS,
    input  logic                          ABORT,
    output logic                          BUSY,
    output logic                          DONE,
    output logic                          ERR,
    output logic [BLK_WIDTH-1:0]          BLK_SEL,
    output logic                          IG_ST,
    input  logic                          IG_RD,
    input  logic [LANES*DATA_WIDTH-1:0]   IG_OUT,
    output logic                          RES_WE,
    output logic [RES_ADDR_WIDTH-1:0]     RES_ADDR,
    output logic [DATA_WIDTH-1:0]         RES_DATA
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [LANE_W-1:0]         LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [TMR_W-1:0]          TMO_VAL   = TMR_W'(TIMEOUT);
    localparam logic [RES_ADDR_WIDTH-1:0] LANES_A   = RES_ADDR_WIDTH'(LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN,
        S_FIN,
        S_ERROR
    } state_t;

    state_t                        state_q, state_d;
    logic [BLK_WIDTH-1:0]          num_q, num_d;
    logic [BLK_WIDTH-1:0]          blk_q, blk_d;
    logic [LANE_W-1:0]             lane_q, lane_d;
    logic [TMR_W-1:0]              timer_q, timer_d;
    logic [LANES*DATA_WIDTH-1:0]   shadow_q, shadow_d;
    logic                          rd_q;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic                          ig_st_q, ig_st_d;
    logic                          res_we_q, res_we_d;
    logic [RES_ADDR_WIDTH-1:0]     res_addr_q, res_addr_d;
    logic [DATA_WIDTH-1:0]         res_data_q, res_data_d;
    logic                          rd_edge;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        blk_d    = blk_q;
        lane_d   = lane_q;
        timer_d  = timer_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        done_d   = 1'b0;
        rd_edge  = IG_RD & ~rd_q;

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    err_d = 1'b0;
                    if (NUM_BLOCKS != '0) begin
                        num_d   = NUM_BLOCKS;
                        blk_d   = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An edge on the last permitted cycle still wins over the timeout.
                timer_d = timer_q + 1'b1;
                if (rd_edge) begin
                    state_d = S_CAPTURE;
                end else if (timer_d == TMO_VAL) begin
                    state_d = S_ERROR;
                end
            end
            S_CAPTURE: begin
                shadow_d = IG_OUT;
                lane_d   = '0;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                if (lane_q == LAST_LANE) begin
                    if (blk_q == num_q - 1'b1) begin
                        state_d = S_FIN;
                    end else begin
                        blk_d   = blk_q + 1'b1;
                        state_d = S_LAUNCH;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (ABORT && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end

        if (state_d == S_ERROR) begin
            err_d = 1'b1;
        end
        if (state_d == S_FIN) begin
            done_d = 1'b1;
        end

        // Outputs are computed from next-state values so the registers line up with the state.
        busy_d     = (state_d == S_LAUNCH) || (state_d == S_WAIT) ||
                     (state_d == S_CAPTURE) || (state_d == S_DRAIN);
        ig_st_d    = (state_d == S_LAUNCH);
        res_we_d   = (state_d == S_DRAIN);
        res_data_d = shadow_d[int'(lane_d)*DATA_WIDTH +: DATA_WIDTH];
        res_addr_d = RES_ADDR_WIDTH'(blk_d) * LANES_A + RES_ADDR_WIDTH'(lane_d);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            blk_q      <= '0;
            lane_q     <= '0;
            timer_q    <= '0;
            shadow_q   <= '0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ig_st_q    <= 1'b0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            blk_q      <= blk_d;
            lane_q     <= lane_d;
            timer_q    <= timer_d;
            shadow_q   <= shadow_d;
            rd_q       <= IG_RD;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ig_st_q    <= ig_st_d;
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign BLK_SEL  = blk_q;
    assign IG_ST    = ig_st_q;
    assign RES_WE   = res_we_q;
    assign RES_ADDR = res_addr_q;
    assign RES_DATA = res_data_q;

endmodule

// File: tb/tb_igmv_block_sched.sv
// tb/tb_igmv_block_sched.sv - scoreboard bench for igmv_block_sched with an igmv engine stub
module tb_igmv_block_sched;

    localparam int LANES = 10;
    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int AW    = 12;

    logic                  CLK = 1'b0;
    logic                  RST, START, ABORT;
    logic [BW-1:0]         NUM_BLOCKS;
    logic                  BUSY, DONE, ERR, IG_ST, IG_RD, RES_WE;
    logic [BW-1:0]         BLK_SEL;
    logic [LANES*DW-1:0]   IG_OUT;
    logic [AW-1:0]         RES_ADDR;
    logic [DW-1:0]         RES_DATA;

    always #5 CLK = ~CLK;

    igmv_block_sched dut (
        .CLK(CLK), .RST(RST), .START(START), .NUM_BLOCKS(NUM_BLOCKS), .ABORT(ABORT),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .BLK_SEL(BLK_SEL), .IG_ST(IG_ST),
        .IG_RD(IG_RD), .IG_OUT(IG_OUT), .RES_WE(RES_WE), .RES_ADDR(RES_ADDR),
        .RES_DATA(RES_DATA)
    );

    typedef struct {
        longint addr;
        longint data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   st_cnt   = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    bit   busy_seen = 0;
    int   rd_delay = 20;
    bit   rd_hold  = 0;
    bit   pat_mode = 1;
    int   rd_cnt   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Engine stub and reference model: each ST yields one block whose writes are predicted here.
    initial begin
        IG_RD  = 1'b0;
        IG_OUT = '0;
        forever begin
            @(negedge CLK);
            if (IG_ST && !rd_hold) begin
                for (int k = 0; k < LANES; k++) begin
                    longint w;
                    w = pat_mode ? longint'(BLK_SEL) * 100 + k : longint'($urandom);
                    IG_OUT[k*DW +: DW] = DW'(w);
                    exp_q.push_back('{addr: (longint'(BLK_SEL) * LANES + k) % (1 << AW), data: w});
                end
                IG_RD  = 1'b0;
                rd_cnt = rd_delay;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) IG_RD = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (IG_ST) st_cnt++;
            if (DONE)  done_cnt++;
            if (BUSY)  busy_seen = 1;
            if (RES_WE) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wr_unexpected: addr %0d data %0d with no write pending", RES_ADDR, RES_DATA);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", longint'(RES_ADDR), e.addr);
                    check("wr_data", longint'(RES_DATA), e.data);
                end
            end
        end
    end

    task automatic pulse_start(input int n);
        START      = 1'b1;
        NUM_BLOCKS = BW'(n);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cyc, output bit gd, output bit ge);
        cyc = 0; gd = 0; ge = 0;
        while (cyc < budget && !gd && !ge) begin
            @(negedge CLK);
            cyc++;
            gd = DONE;
            ge = ERR;
        end
        if (!gd && !ge) begin
            n_checks++;
            $display("FAIL wait_end: no DONE or ERR within %0d cycles", budget);
        end
    endtask

    task automatic wait_we_addr(input int addr, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if (RES_WE && RES_ADDR == AW'(addr)) ok = 1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL wait_we: no write to addr %0d within %0d cycles", addr, budget);
        end
    endtask

    task automatic run_job(input int n, input int d, input string tag);
        int s0, w0, d0, cyc;
        bit gd, ge;
        rd_delay = d;
        s0 = st_cnt; w0 = wr_cnt; d0 = done_cnt;
        pulse_start(n);
        check({tag, "_err_clear"}, ERR, 0);
        wait_end(n * (d + 12) + 20, cyc, gd, ge);
        check({tag, "_done"}, gd, 1);
        check({tag, "_latency"}, cyc, n * (d + 12));
        @(negedge CLK);
        check({tag, "_st_count"}, st_cnt - s0, n);
        check({tag, "_wr_count"}, wr_cnt - w0, n * LANES);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_err"}, ERR, 0);
        check({tag, "_busy_after"}, BUSY, 0);
        check({tag, "_done_pulse"}, DONE, 0);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int  s0, w0, d0, cyc;
        bit  gd, ge;

        RST = 1'b0; START = 1'b0; ABORT = 1'b0; NUM_BLOCKS = '0;
        repeat (3) @(negedge CLK);
        check("rst_outs", {BUSY, DONE, ERR, IG_ST, RES_WE}, 0);
        check("rst_blk_addr", {BLK_SEL, RES_ADDR}, 0);
        check("rst_data", RES_DATA, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        pat_mode = 1;
        run_job(3, 20, "basic3");

        // Zero-block job: DONE one cycle after START, nothing else moves.
        busy_seen = 0; s0 = st_cnt; w0 = wr_cnt; d0 = done_cnt;
        pulse_start(0);
        check("zero_done", DONE, 1);
        check("zero_busy", BUSY, 0);
        @(negedge CLK);
        check("zero_done_pulse", DONE, 0);
        repeat (5) @(negedge CLK);
        check("zero_st", st_cnt - s0, 0);
        check("zero_wr", wr_cnt - w0, 0);
        check("zero_done_count", done_cnt - d0, 1);
        check("zero_busy_seen", busy_seen, 0);

        // RD held high with no rising edge: timeout after 255 WAIT cycles.
        rd_hold = 1; IG_RD = 1'b1;
        repeat (2) @(negedge CLK);
        s0 = st_cnt; w0 = wr_cnt; d0 = done_cnt;
        pulse_start(1);
        wait_end(400, cyc, gd, ge);
        check("tmo_err", ge, 1);
        check("tmo_cycles", cyc, 256);
        check("tmo_busy", BUSY, 0);
        repeat (3) @(negedge CLK);
        check("tmo_err_sticky", ERR, 1);
        check("tmo_no_done", done_cnt - d0, 0);
        check("tmo_no_wr", wr_cnt - w0, 0);
        check("tmo_one_st", st_cnt - s0, 1);
        rd_hold = 0;
        run_job(1, 10, "after_err");

        // Abort during DRAIN of block 0, lane 4.
        d0 = done_cnt; w0 = wr_cnt;
        rd_delay = int'($urandom_range(3, 10));
        pulse_start(2);
        wait_we_addr(4, 100);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_we", RES_WE, 0);
        check("abort_busy", BUSY, 0);
        check("abort_pending", exp_q.size(), 5);
        check("abort_wr", wr_cnt - w0, 5);
        exp_q.delete();
        repeat (30) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_err", ERR, 0);
        run_job(2, 7, "rerun");

        // ABORT together with START in IDLE drops the START.
        s0 = st_cnt;
        ABORT = 1'b1;
        pulse_start(4);
        ABORT = 1'b0;
        check("abort_start_busy", BUSY, 0);
        repeat (5) @(negedge CLK);
        check("abort_start_st", st_cnt - s0, 0);

        // Async reset in the middle of WAIT.
        rd_delay = 50;
        s0 = st_cnt;
        pulse_start(1);
        repeat (10) @(negedge CLK);
        check("midwait_busy", BUSY, 1);
        #2 RST = 1'b0;
        #1 check("async_rst_outs", {BUSY, DONE, ERR, IG_ST, RES_WE, BLK_SEL}, 0);
        check("async_rst_addr_data", {RES_ADDR, RES_DATA}, 0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        s0 = st_cnt; w0 = wr_cnt;
        repeat (60) @(negedge CLK);
        check("post_rst_busy", BUSY, 0);
        check("post_rst_st", st_cnt - s0, 0);
        check("post_rst_wr", wr_cnt - w0, 0);

        // START pulses while busy and during DRAIN are ignored.
        s0 = st_cnt; w0 = wr_cnt; d0 = done_cnt;
        rd_delay = 15;
        pulse_start(2);
        repeat (3) @(negedge CLK);
        pulse_start(5);
        wait_we_addr(0, 100);
        pulse_start(7);
        wait_end(200, cyc, gd, ge);
        check("ign_start_done", gd, 1);
        @(negedge CLK);
        check("ign_start_st", st_cnt - s0, 2);
        check("ign_start_wr", wr_cnt - w0, 2 * LANES);
        check("ign_start_done_count", done_cnt - d0, 1);

        // Edge on the final permitted WAIT cycle still completes.
        run_job(1, 255, "edge_last");

        pat_mode = 0;
        for (int i = 0; i < 6; i++) begin
            run_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 30)), "rand");
        end

        repeat (5) @(negedge CLK);
        check("final_sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
